sub_digit_serial: RTL

//  - Multi-cycle unsigned subtractor, o = a - b, with borrow-out; the inverse-direction companion to the 16-bit combinational adder DUT.
//  - Processes DIGIT_W bits per clock, LSB first. Valid/ready on both input and result side.
//  - Gives the simulator a sequential, handshaked arithmetic DUT; results cross-check against the adder (a == o + b).

---
 rtl/sub_digit_serial_pkg.sv | 15 +
 rtl/sub_digit_serial_if.sv | 23 ++
 rtl/sub_digit_serial_cell.sv | 17 +
 rtl/sub_digit_serial.sv | 99 +++++++++
 4 files changed

// File: rtl/sub_digit_serial_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH/DIGIT_W.
  function automatic int cnt_w(input int width, input int digit_w);
    return $clog2(width / digit_w + 1);
  endfunction

endpackage

// File: rtl/sub_digit_serial_if.sv
// Operand/result bundle for sub_digit_serial.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the source holds its payload and valid until then, the sink may drop ready freely.
interface sub_digit_serial_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o;
  logic             borrow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, o, borrow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, o, borrow
  );
endinterface

// File: rtl/sub_digit_serial_cell.sv
// Combinational DIGIT_W-bit subtract: {bo,d} = a - b - bi.
module sub_digit_cell #(
  parameter int DIGIT_W = 1
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bi,
  output logic [DIGIT_W-1:0] d,
  output logic               bo
);
  logic [DIGIT_W:0] diff;

  // A negative result sets the extra top bit, which is exactly the borrow out.
  assign diff = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bi};
  assign d    = diff[DIGIT_W-1:0];
  assign bo   = diff[DIGIT_W];
endmodule

// File: rtl/sub_digit_serial.sv
// Digit-serial unsigned subtractor o = a - b, LSB digit first, with borrow out.
// Optional build macro SUB_SAT_EN: clamp o to 0 when the final borrow is set.
module sub_digit_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DIGIT_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sub_digit_serial_if.slave        bus,
  output state_t                   state
);
  localparam int N  = WIDTH / DIGIT_W;
  localparam int CW = cnt_w(WIDTH, DIGIT_W);

  if (WIDTH % DIGIT_W != 0) begin : g_bad_digit
    $error("sub_digit_serial: WIDTH must be a multiple of DIGIT_W");
  end

  state_t             state_q, state_d;
  logic               in_ready_q, out_valid_q;
  logic [WIDTH-1:0]   a_sh, b_sh, res_q, res_next;
  logic [WIDTH+DIGIT_W-1:0] res_cat;
  logic               borrow_q;
  logic [CW-1:0]      cnt_q;
  logic               accept, last_digit;
  logic [DIGIT_W-1:0] cell_d;
  logic               cell_bo;

  sub_digit_cell #(.DIGIT_W(DIGIT_W)) u_cell (
    .a  (a_sh[DIGIT_W-1:0]),
    .b  (b_sh[DIGIT_W-1:0]),
    .bi (borrow_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign accept     = (state_q == ST_IDLE) && in_ready_q && bus.in_valid;
  assign last_digit = (cnt_q == CW'(N - 1));

  // New digit enters at the MSB so the result is aligned after N shifts.
  assign res_cat = {cell_d, res_q};
  always_comb begin
    res_next = res_cat[WIDTH+DIGIT_W-1:DIGIT_W];
`ifdef SUB_SAT_EN
    if (last_digit && cell_bo) res_next = '0;
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last_digit) state_d = ST_DONE;
      ST_DONE: if (out_valid_q && bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      a_sh        <= '0;
      b_sh        <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      if (accept) begin
        a_sh     <= bus.a;
        b_sh     <= bus.b;
        res_q    <= '0;
        borrow_q <= 1'b0;
        cnt_q    <= '0;
      end else if (state_q == ST_RUN) begin
        a_sh     <= a_sh >> DIGIT_W;
        b_sh     <= b_sh >> DIGIT_W;
        res_q    <= res_next;
        borrow_q <= cell_bo;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.o         = res_q;
  assign bus.borrow    = borrow_q;
  assign state         = state_q;
endmodule
